// File: rtl/wb_master_port.sv
// ============================================================================
// Module : wb_master_port
// Brief  : Wishbone classic single-transfer master behind a valid/ready
//          request port. Optional bus timeout via WB_MASTER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_master_port #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_sel,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic        r_we;
   logic [3:0]  r_sel;
   logic        r_cyc;
   logic        w_timeout;
   logic        w_bus_end;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Counter is zero on the first BUS cycle and advances once per BUS cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == S_BUS) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   assign w_timeout = (r_state == S_BUS) && (r_cnt == c_CNT_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   assign w_bus_end = wbm_ack_i | wbm_err_i | w_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
         r_adr       <= 32'd0;
         r_dat       <= 32'd0;
         r_we        <= 1'b0;
         r_sel       <= 4'd0;
         r_cyc       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_adr       <= req_addr;
                  r_dat       <= req_wdata;
                  r_we        <= req_we;
                  r_sel       <= req_sel;
                  r_cyc       <= 1'b1;
                  r_req_ready <= 1'b0;
                  r_state     <= S_BUS;
               end
            end
            S_BUS: begin
               // A real ack on the timeout cycle still completes normally.
               if (w_bus_end) begin
                  r_cyc       <= 1'b0;
                  r_we        <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= wbm_err_i | (~wbm_ack_i & w_timeout);
                  r_rsp_rdata <= (wbm_ack_i && !wbm_err_i && !r_we) ? wbm_dat_i : 32'd0;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_cyc       <= 1'b0;
               r_we        <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_port.sv
// ============================================================================
// Module : tb_wb_master_port
// Brief  : Directed self-checking bench for wb_master_port with a
//          registered-ack memory slave model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_master_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_sel;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   int n_checks = 0;
   int n_fail   = 0;

   // 0 = normal ack, 1 = ack and err together, 2 = never respond
   int slv_mode = 0;
   logic [31:0] mem [0:15];

   always #5 clk = ~clk;

   wb_master_port #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_wdata (req_wdata),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i)
   );

   // Registered-ack slave: acks one cycle after seeing cyc/stb, never twice in a row.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wbm_ack_i <= 1'b0;
         wbm_err_i <= 1'b0;
         wbm_dat_i <= 32'd0;
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | i;
         mem[4] <= 32'hDEAD_BEEF;
      end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && slv_mode != 2) begin
         wbm_ack_i <= 1'b1;
         wbm_err_i <= (slv_mode == 1);
         if (wbm_we_o) begin
            for (int b = 0; b < 4; b++)
               if (wbm_sel_o[b]) mem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
         end else begin
            wbm_dat_i <= mem[wbm_adr_o[5:2]];
         end
      end else begin
         wbm_ack_i <= 1'b0;
         wbm_err_i <= 1'b0;
      end
   end

   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_we    = w;
      req_wdata = d;
      req_sel   = s;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0; req_wdata = 32'd0; req_sel = 4'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 100000",
                  {req_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
      end
      n_checks++;
      if ({rsp_rdata, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 100'd0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h adr=%h dat=%h sel=%h expected all 0",
                  rsp_rdata, wbm_adr_o, wbm_dat_o, wbm_sel_o);
      end
   endtask

   task automatic test_read;
      issue(32'h10, 1'b0, 32'd0, 4'hF);
      n_checks++;
      if ({wbm_cyc_o, wbm_stb_o, req_ready} !== 3'b110 || wbm_adr_o !== 32'h10) begin
         n_fail++;
         $display("FAIL read_start: cyc=%b stb=%b ready=%b adr=%h expected 1 1 0 00000010",
                  wbm_cyc_o, wbm_stb_o, req_ready, wbm_adr_o);
      end
      @(negedge clk);
      n_checks++;
      if ({wbm_cyc_o, rsp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL read_wait: cyc=%b rsp_valid=%b expected 1 0", wbm_cyc_o, rsp_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_err, wbm_cyc_o} !== 3'b100 || rsp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL read_rsp: valid=%b err=%b cyc=%b rdata=%h expected 1 0 0 deadbeef",
                  rsp_valid, rsp_err, wbm_cyc_o, rsp_rdata);
      end
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready} !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL read_done: valid=%b ready=%b rdata=%h expected 0 1 deadbeef",
                  rsp_valid, req_ready, rsp_rdata);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  cyc_h, ack_h, rsp_h;
      logic [31:0] rd0, rd1;
      cyc_h = '0; ack_h = '0; rsp_h = '0; rd0 = '0; rd1 = '0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0; req_we = 1'b0; req_sel = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         cyc_h[k] = wbm_cyc_o;
         ack_h[k] = wbm_ack_i;
         rsp_h[k] = rsp_valid;
         if (k == 0) req_addr = 32'h4;
         if (k == 4) req_valid = 1'b0;
         if (k == 2) rd0 = rsp_rdata;
         if (k == 6) rd1 = rsp_rdata;
      end
      n_checks++;
      if ({cyc_h, ack_h, rsp_h} !== {8'b0011_0011, 8'b0010_0010, 8'b0100_0100}) begin
         n_fail++;
         $display("FAIL b2b_timing: cyc=%b ack=%b rsp=%b expected 00110011 00100010 01000100",
                  cyc_h, ack_h, rsp_h);
      end
      n_checks++;
      if (rd0 !== 32'hA000_0000 || rd1 !== 32'hA000_0001) begin
         n_fail++;
         $display("FAIL b2b_data: rd0=%h rd1=%h expected a0000000 a0000001", rd0, rd1);
      end
      n_checks++;
      if ({req_ready, wbm_cyc_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_idle: ready=%b cyc=%b expected 1 0", req_ready, wbm_cyc_o);
      end
   endtask

   task automatic test_write;
      issue(32'h8, 1'b1, 32'h1234_5678, 4'hC);
      n_checks++;
      if ({wbm_cyc_o, wbm_we_o} !== 2'b11 || wbm_dat_o !== 32'h1234_5678 || wbm_sel_o !== 4'hC) begin
         n_fail++;
         $display("FAIL write_start: cyc=%b we=%b dat=%h sel=%h expected 1 1 12345678 c",
                  wbm_cyc_o, wbm_we_o, wbm_dat_o, wbm_sel_o);
      end
      @(negedge clk);
      n_checks++;
      if ({wbm_cyc_o, wbm_we_o} !== 2'b11 || wbm_dat_o !== 32'h1234_5678 ||
          wbm_sel_o !== 4'hC || wbm_adr_o !== 32'h8) begin
         n_fail++;
         $display("FAIL write_hold: cyc=%b we=%b dat=%h sel=%h adr=%h expected 1 1 12345678 c 00000008",
                  wbm_cyc_o, wbm_we_o, wbm_dat_o, wbm_sel_o, wbm_adr_o);
      end
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_err, wbm_we_o, wbm_cyc_o} !== 4'b1000 || rsp_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL write_rsp: valid=%b err=%b we=%b cyc=%b rdata=%h expected 1 0 0 0 00000000",
                  rsp_valid, rsp_err, wbm_we_o, wbm_cyc_o, rsp_rdata);
      end
      @(negedge clk);
      issue(32'h8, 1'b0, 32'd0, 4'hF);
      repeat (2) @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_0002) begin
         n_fail++;
         $display("FAIL write_readback: valid=%b rdata=%h expected 1 12340002", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_ack_err;
      slv_mode = 1;
      issue(32'h10, 1'b0, 32'd0, 4'hF);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL ack_err_rsp: valid=%b err=%b rdata=%h expected 1 1 00000000",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL ack_err_clear: valid=%b err=%b ready=%b expected 0 0 1",
                  rsp_valid, rsp_err, req_ready);
      end
      slv_mode = 0;
   endtask

   task automatic test_timeout;
      slv_mode = 2;
      issue(32'h10, 1'b0, 32'd0, 4'hF);
`ifdef WB_MASTER_TIMEOUT_EN
      begin
         int hi;
         hi = 0;
         for (int k = 0; k < 40; k++) begin
            if (!wbm_cyc_o) break;
            hi++;
            @(negedge clk);
         end
         n_checks++;
         if (hi != 8 || {rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout: bus_cycles=%0d valid=%b err=%b rdata=%h expected 8 1 1 00000000",
                     hi, rsp_valid, rsp_err, rsp_rdata);
         end
         slv_mode = 0;
         repeat (2) @(negedge clk);
         n_checks++;
         if ({wbm_cyc_o, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_after: cyc=%b valid=%b ready=%b expected 0 0 1",
                     wbm_cyc_o, rsp_valid, req_ready);
         end
      end
`else
      begin
         int bad;
         bad = 0;
         repeat (1000) begin
            @(negedge clk);
            if (!wbm_cyc_o || rsp_valid) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL no_timeout: %0d cycles without cyc or with rsp_valid, expected 0", bad);
         end
         slv_mode = 0;
         repeat (2) @(negedge clk);
         n_checks++;
         if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL late_ack: valid=%b err=%b rdata=%h expected 1 0 deadbeef",
                     rsp_valid, rsp_err, rsp_rdata);
         end
         @(negedge clk);
      end
`endif
   endtask

   task automatic test_reset_mid;
      int bad;
      slv_mode = 2;
      issue(32'h20, 1'b0, 32'd0, 4'hF);
      n_checks++;
      if (wbm_cyc_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: cyc=%b expected 1", wbm_cyc_o);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({wbm_cyc_o, wbm_stb_o, req_ready, rsp_valid} !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_mid_async: cyc=%b stb=%b ready=%b valid=%b expected 0 0 1 0",
                  wbm_cyc_o, wbm_stb_o, req_ready, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      slv_mode = 0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || wbm_cyc_o || !req_ready) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rst_mid_after: %0d cycles with response/cycle/not-ready, expected 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_back_to_back();
      test_write();
      test_ack_err();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
